// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS load/store initiator for a word-wide, little-endian data port.
// Handles LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW with alignment and illegal-op faults.
// Default build: the port has no byte enables, so SB/SH use read-modify-write.
// Optional macro MEM_BYTE_ENABLE_EN adds data_byteenable[3:0] and single-cycle SB/SH.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_write,
    output logic [DATA_W-1:0] data_writedata,
`ifdef MEM_BYTE_ENABLE_EN
    output logic [3:0]        data_byteenable,
`endif
    input  logic [DATA_W-1:0] data_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DONE,
        WR,
        RMW_MERGE,
        FAULT
    } state_t;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } op_t;

    localparam logic [DATA_W-1:0] ONES      = '1;
    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(32'h0000_00FF);
    localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(32'h0000_FFFF);

    state_t            state, state_nx;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_fault;
    logic [1:0]        lane;
    logic [4:0]        sh_lo;
    logic [4:0]        sh_hi;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] lane_ins;
    logic [DATA_W-1:0] merge_data;
    logic [ADDR_W-1:0] word_addr;

    // Byte-lane shift amounts: sh_lo = 8*b, sh_hi = 8*(3-b) (3-b is ~b on two bits).
    assign lane      = addr_q[1:0];
    assign sh_lo     = {lane, 3'b000};
    assign sh_hi     = {~lane, 3'b000};
    assign rd_shift  = data_readdata >> sh_lo;
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // Request-state register and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            if (req_valid && state == IDLE) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Alignment and legality check on the incoming request.
    always_comb begin
        req_fault = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: req_fault = 1'b0;
            OP_LH, OP_LHU, OP_SH:                 req_fault = req_addr[0];
            OP_LW, OP_SW:                         req_fault = |req_addr[1:0];
            default:                              req_fault = 1'b1;
        endcase
    end

    // Load result formatting from the returned word.
    always_comb begin
        load_data = '0;
        case (op_q)
            OP_LB:   load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU:  load_data = {24'b0, rd_shift[7:0]};
            OP_LH:   load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            OP_LHU:  load_data = {16'b0, rd_shift[15:0]};
            OP_LW:   load_data = data_readdata;
            // Unaligned-left: memory bytes fill the top, rt keeps the low 8*(3-b) bits.
            OP_LWL:  load_data = (data_readdata << sh_hi) | (wdata_q & ~(ONES << sh_hi));
            // Unaligned-right: memory bytes fill the bottom, rt keeps the high 8*b bits.
            OP_LWR:  load_data = (data_readdata >> sh_lo) | (wdata_q & ~(ONES >> sh_lo));
            default: load_data = '0;
        endcase
    end

    // Read-modify-write merge: replace the target lane(s) of the read word.
    always_comb begin
        if (op_q == OP_SB) begin
            lane_mask = BYTE_MASK << sh_lo;
            lane_ins  = {24'b0, wdata_q[7:0]} << sh_lo;
        end else begin
            lane_mask = HALF_MASK << sh_lo;
            lane_ins  = {16'b0, wdata_q[15:0]} << sh_lo;
        end
        merge_data = (data_readdata & ~lane_mask) | (lane_ins & lane_mask);
    end

    // Next-state and output decode.
    always_comb begin
        state_nx       = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_fault     = 1'b0;
        resp_rdata     = '0;
        data_address   = '0;
        data_write     = 1'b0;
        data_writedata = '0;
`ifdef MEM_BYTE_ENABLE_EN
        data_byteenable = 4'b0000;
`endif
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault) begin
                        state_nx = FAULT;
                    end else if (req_op == OP_SW) begin
                        state_nx = WR;
`ifdef MEM_BYTE_ENABLE_EN
                    end else if (req_op == OP_SB || req_op == OP_SH) begin
                        state_nx = WR;
`endif
                    end else begin
                        state_nx = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                data_address = word_addr;
                // Only legal ops reach here; bit 3 set marks the sub-word stores.
                state_nx = op_q[3] ? RMW_MERGE : RD_DONE;
            end
            RD_DONE: begin
                resp_valid = 1'b1;
                resp_rdata = load_data;
                state_nx   = IDLE;
            end
            WR: begin
                data_address = word_addr;
                data_write   = 1'b1;
                resp_valid   = 1'b1;
                state_nx     = IDLE;
`ifdef MEM_BYTE_ENABLE_EN
                case (op_q)
                    OP_SB: begin
                        data_writedata  = {4{wdata_q[7:0]}};
                        data_byteenable = 4'b0001 << lane;
                    end
                    OP_SH: begin
                        data_writedata  = {2{wdata_q[15:0]}};
                        data_byteenable = 4'b0011 << lane;
                    end
                    default: begin
                        data_writedata  = wdata_q;
                        data_byteenable = 4'b1111;
                    end
                endcase
`else
                data_writedata = wdata_q;
`endif
            end
            RMW_MERGE: begin
                data_address   = word_addr;
                data_write     = 1'b1;
                data_writedata = merge_data;
                resp_valid     = 1'b1;
`ifdef MEM_BYTE_ENABLE_EN
                data_byteenable = 4'b1111;
`endif
                state_nx = IDLE;
            end
            FAULT: begin
                resp_valid = 1'b1;
                resp_fault = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized load/store traffic against a byte-array reference model.
// Build with MEM_BYTE_ENABLE_EN defined to exercise the byte-enable variant.
module tb_mem_access_unit;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] data_address;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
`ifdef MEM_BYTE_ENABLE_EN
    logic [3:0]  data_byteenable;
    localparam bit BE_MODE = 1'b1;
`else
    localparam bit BE_MODE = 1'b0;
`endif

    logic        mem_init;
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned wr_cnt   = 0;
    int unsigned resp_cnt = 0;
    logic [31:0] wr_addr_last = '0;
    logic [3:0]  be_last      = '0;

    // Clock generation.
    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_writedata (data_writedata),
`ifdef MEM_BYTE_ENABLE_EN
        .data_byteenable(data_byteenable),
`endif
        .data_readdata  (data_readdata)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'h8899_AABB ^ (i * 32'h0123_4567);
    endfunction

    // Data memory: registered read (one-cycle latency), writes and activity counters.
    always @(posedge clk) begin
        data_readdata <= mem[data_address[5:2]];
        if (mem_init) begin
            for (int unsigned i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (data_write) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_last <= data_address;
`ifdef MEM_BYTE_ENABLE_EN
            be_last <= data_byteenable;
            for (int k = 0; k < 4; k++)
                if (data_byteenable[k]) mem[data_address[5:2]][8*k +: 8] <= data_writedata[8*k +: 8];
`else
            mem[data_address[5:2]] <= data_writedata;
`endif
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: memory as bytes, results from the architectural rules.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt,
                         output int unsigned lat, output int unsigned nwr);
        logic [7:0]  by [4];
        logic [31:0] w;
        logic [63:0] m;
        int unsigned b;
        int          v;
        w = ref_mem[addr[5:2]];
        b = 32'(addr[1:0]);
        for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
        rd  = '0;
        lat = 2;
        nwr = 0;
        flt = (op == 4'd7) || (op > 4'd10) ||
              ((op == 4'd2 || op == 4'd3 || op == 4'd9) && addr[0]) ||
              ((op == 4'd4 || op == 4'd10) && b != 0);
        if (flt) begin
            lat = 1;
            return;
        end
        case (op)
            4'd0, 4'd1: begin
                v = int'(by[b]);
                if (op == 4'd0 && v >= 128) v = v - 256;
                rd = 32'(v);
            end
            4'd2, 4'd3: begin
                v = int'(by[b]) + 256 * int'(by[b+1]);
                if (op == 4'd2 && v >= 32768) v = v - 65536;
                rd = 32'(v);
            end
            4'd4: rd = w;
            4'd5: begin
                m  = (64'd1 << (8 * (3 - b))) - 64'd1;
                rd = 32'((64'(w) << (8 * (3 - b))) | (64'(wd) & m));
            end
            4'd6: begin
                m  = (64'd1 << (32 - 8 * b)) - 64'd1;
                rd = 32'((64'(w) >> (8 * b)) | (64'(wd) & ~m));
            end
            4'd8: begin
                by[b] = wd[7:0];
                nwr = 1;
                lat = BE_MODE ? 1 : 2;
            end
            4'd9: begin
                by[b]   = wd[7:0];
                by[b+1] = wd[15:8];
                nwr = 1;
                lat = BE_MODE ? 1 : 2;
            end
            default: begin
                for (int k = 0; k < 4; k++) by[k] = wd[8*k +: 8];
                nwr = 1;
                lat = 1;
            end
        endcase
        ref_mem[addr[5:2]] = {by[3], by[2], by[1], by[0]};
    endtask

    // One request: called just after a negedge with the unit idle.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_flt;
        logic        got_flt;
        int unsigned exp_lat, exp_wr, lat, w0, r0;
        model(op, addr, wd, exp_rd, exp_flt, exp_lat, exp_wr);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        w0 = wr_cnt;
        r0 = resp_cnt;
        @(negedge clk);
        // Keep req_valid high with junk while busy; it must be ignored.
        req_op    = 4'($urandom);
        req_addr  = BASE | 32'($urandom_range(0, 63));
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            check("busy_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        got     = resp_rdata;
        got_flt = resp_fault;
        check("resp_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("latency", lat, exp_lat);
        check("fault", 32'(got_flt), 32'(exp_flt));
        check("rdata", got, exp_rd);
        check("writes", wr_cnt - w0, exp_wr);
        check("resps", resp_cnt - r0, 32'd1);
        check("mem_word", mem[addr[5:2]], ref_mem[addr[5:2]]);
        if (exp_wr != 0) check("wr_addr", wr_addr_last, {addr[31:2], 2'b00});
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [3:0]  op;
        logic [3:0]  legal [10];
        int unsigned w0, r0;
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
        reset     = 1'b1;
        mem_init  = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int unsigned i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_data_write", 32'(data_write), 32'd0);
        check("rst_data_address", data_address, 32'd0);
        check("rst_data_writedata", data_writedata, 32'd0);
        reset    = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);

        do_req(4'd0, BASE + 32'd1, 32'd0, r);          check("lb_const", r, 32'hFFFF_FFAA);
        do_req(4'd1, BASE + 32'd1, 32'd0, r);          check("lbu_const", r, 32'h0000_00AA);
        do_req(4'd5, BASE + 32'd1, 32'h1122_3344, r);  check("lwl_const", r, 32'hAABB_3344);
        do_req(4'd6, BASE + 32'd1, 32'h1122_3344, r);  check("lwr_const", r, 32'h1188_99AA);
        do_req(4'd4, BASE + 32'd2, 32'd0, r);          check("lw_fault_rdata", r, 32'd0);

`ifndef MEM_BYTE_ENABLE_EN
        // Reset during the read phase of an SB must abandon it without a write or response.
        req_valid = 1'b1;
        req_op    = 4'd8;
        req_addr  = BASE;
        req_wdata = 32'h55;
        w0 = wr_cnt;
        r0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_write", 32'(data_write), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_writes", wr_cnt - w0, 32'd0);
        check("abort_resps", resp_cnt - r0, 32'd0);
        check("abort_mem", mem[0], 32'h8899_AABB);
`endif

        do_req(4'd9, BASE + 32'd2, 32'h0000_1234, r);
        do_req(4'd4, BASE, 32'd0, r);                  check("sh_then_lw", r, 32'h1234_AABB);
        do_req(4'd10, BASE + 32'd4, 32'hDEAD_BEEF, r);
        do_req(4'd4, BASE + 32'd4, 32'd0, r);          check("sw_then_lw", r, 32'hDEAD_BEEF);
`ifdef MEM_BYTE_ENABLE_EN
        do_req(4'd8, BASE + 32'd3, 32'h0000_0077, r);  check("sb_byteenable", 32'(be_last), 32'h8);
`endif

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) op = legal[$urandom_range(0, 9)];
            else                           op = 4'($urandom);
            a = BASE | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
            do_req(op, a, $urandom, r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int unsigned i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
